// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers and PC.
// Handles load-use bubbles, wrong-path squash on taken branch/jump, and a
// full-pipe freeze while data memory is busy. A watchdog parks the pipe in a
// sticky error state if memory never answers.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; hazards resolved combinationally each cycle
// MEM_WAIT | data memory access outstanding; whole pipe frozen
// ERROR    | memory timeout; pipe frozen, err_o high until reset
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_Rt_i,
    input  logic [4:0]       IFID_Rs_i,
    input  logic [4:0]       IFID_Rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_stall_o,
    output logic             IFID_stall_o,
    output logic             IFID_flush_o,
    output logic             IDEX_stall_o,
    output logic             IDEX_flush_o,
    output logic             EXMEM_stall_o,
    output logic             MEMWB_flush_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int WCNT_W = $clog2(MAX_WAIT) + 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic mem_busy;

    // Register 0 is hardwired zero, so a load targeting it never creates a hazard.
    assign load_use = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                      ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));
    assign mem_busy = dmem_req_i && !dmem_ready_i;

    // Hazard priority, control outputs and next-state / watchdog decision.
    always_comb begin
        pc_stall_o    = 1'b0;
        IFID_stall_o  = 1'b0;
        IFID_flush_o  = 1'b0;
        IDEX_stall_o  = 1'b0;
        IDEX_flush_o  = 1'b0;
        EXMEM_stall_o = 1'b0;
        MEMWB_flush_o = 1'b0;
        err_o         = 1'b0;
        state_d       = state_q;
        wait_d        = wait_q;

        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    pc_stall_o    = 1'b1;
                    IFID_stall_o  = 1'b1;
                    IDEX_stall_o  = 1'b1;
                    EXMEM_stall_o = 1'b1;
                    MEMWB_flush_o = 1'b1;
                    state_d       = MEM_WAIT;
                    wait_d        = WCNT_W'(1);
                end else if (load_use) begin
                    // Branch/jump in ID is held and re-resolved after the bubble.
                    pc_stall_o   = 1'b1;
                    IFID_stall_o = 1'b1;
                    IDEX_flush_o = 1'b1;
                end else if (branch_taken_i || jump_i) begin
                    IFID_flush_o = 1'b1;
                end
            end
            MEM_WAIT: begin
                pc_stall_o    = 1'b1;
                IFID_stall_o  = 1'b1;
                IDEX_stall_o  = 1'b1;
                EXMEM_stall_o = 1'b1;
                MEMWB_flush_o = 1'b1;
                if (dmem_ready_i) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + WCNT_W'(1);
                end
            end
            ERROR: begin
                pc_stall_o    = 1'b1;
                IFID_stall_o  = 1'b1;
                IDEX_stall_o  = 1'b1;
                EXMEM_stall_o = 1'b1;
                MEMWB_flush_o = 1'b1;
                err_o         = 1'b1;
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Saturating count of PC-stall cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_stall_o && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    assign stall_cnt_o = stall_cnt_q;

    // State, watchdog and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (default parameters and a
// small MAX_WAIT=4 / CNT_W=3 build) share directed stimulus. A behavioural
// model checks both every cycle; literal checks pin key scenarios.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       memrd;
    logic [4:0] ex_rt, id_rs, id_rt;
    logic       br, jmp, req, rdy;

    logic        pc_a, ifs_a, iff_a, ids_a, idf_a, exs_a, mwf_a, err_a;
    logic        pc_b, ifs_b, iff_b, ids_b, idf_b, exs_b, mwf_b, err_b;
    logic [31:0] cnt_a;
    logic [2:0]  cnt_b;
    logic [7:0]  vec_a, vec_b;

    int total = 0;
    int bad   = 0;

    // per-instance model: mode 0=running 1=waiting on memory 2=timed out
    int                mw[2] = '{64, 4};
    longint unsigned   cmax[2] = '{64'hFFFF_FFFF, 64'd7};
    int                m_mode[2];
    int                m_n[2];
    longint unsigned   m_cnt[2];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut_a (
        .clk(clk), .rst(rst),
        .IDEX_MemRead_i(memrd), .IDEX_Rt_i(ex_rt), .IFID_Rs_i(id_rs), .IFID_Rt_i(id_rt),
        .branch_taken_i(br), .jump_i(jmp), .dmem_req_i(req), .dmem_ready_i(rdy),
        .pc_stall_o(pc_a), .IFID_stall_o(ifs_a), .IFID_flush_o(iff_a),
        .IDEX_stall_o(ids_a), .IDEX_flush_o(idf_a), .EXMEM_stall_o(exs_a),
        .MEMWB_flush_o(mwf_a), .err_o(err_a), .stall_cnt_o(cnt_a)
    );

    pipeline_hazard_ctrl #(.MAX_WAIT(4), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst),
        .IDEX_MemRead_i(memrd), .IDEX_Rt_i(ex_rt), .IFID_Rs_i(id_rs), .IFID_Rt_i(id_rt),
        .branch_taken_i(br), .jump_i(jmp), .dmem_req_i(req), .dmem_ready_i(rdy),
        .pc_stall_o(pc_b), .IFID_stall_o(ifs_b), .IFID_flush_o(iff_b),
        .IDEX_stall_o(ids_b), .IDEX_flush_o(idf_b), .EXMEM_stall_o(exs_b),
        .MEMWB_flush_o(mwf_b), .err_o(err_b), .stall_cnt_o(cnt_b)
    );

    assign vec_a = {pc_a, ifs_a, iff_a, ids_a, idf_a, exs_a, mwf_a, err_a};
    assign vec_b = {pc_b, ifs_b, iff_b, ids_b, idf_b, exs_b, mwf_b, err_b};

    // vector order: pc_stall IFID_stall IFID_flush IDEX_stall IDEX_flush EXMEM_stall MEMWB_flush err
    function automatic logic [7:0] model_vec(input int k);
        logic hazard;
        hazard = memrd && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
        if (m_mode[k] == 2)                 return 8'b1101_0111;
        if (m_mode[k] == 1 || (req && !rdy)) return 8'b1101_0110;
        if (hazard)                         return 8'b1100_1000;
        if (br || jmp)                      return 8'b0010_0000;
        return 8'b0000_0000;
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model advance on each clock edge
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [7:0] v;
            v = model_vec(k);
            if (rst) begin
                m_mode[k] = 0; m_n[k] = 0; m_cnt[k] = 0;
            end else begin
                if (v[7] && m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
                if (m_mode[k] == 0) begin
                    if (req && !rdy) begin m_mode[k] = 1; m_n[k] = 2; end
                end else if (m_mode[k] == 1) begin
                    if (rdy) m_mode[k] = 0;
                    else if (m_n[k] == mw[k]) m_mode[k] = 2;
                    else m_n[k] = m_n[k] + 1;
                end
            end
        end
    end

    // per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if ($time > 20) begin
            check("model_vec_a", vec_a, model_vec(0));
            check("model_vec_b", vec_b, model_vec(1));
            check("model_cnt_a", cnt_a, m_cnt[0]);
            check("model_cnt_b", cnt_b, m_cnt[1]);
        end
    end

    task automatic drive(input logic r, input logic mr, input logic [4:0] xrt,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic b, input logic j, input logic q, input logic y);
        rst = r; memrd = mr; ex_rt = xrt; id_rs = rs; id_rt = rt;
        br = b; jmp = j; req = q; rdy = y;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        m_mode = '{0, 0}; m_n = '{0, 0}; m_cnt = '{0, 0};
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_vec_a", vec_a, 8'h00);
        check("reset_cnt_a", cnt_a, 0);
        check("reset_cnt_b", cnt_b, 0);

        // load-use on rs: single bubble
        next_cycle();
        drive(0, 1, 5'd2, 5'd2, 5'd7, 0, 0, 0, 0);
        check("lu_rs_vec", vec_a, 8'b1100_1000);
        next_cycle();
        drive(0, 0, 5'd2, 5'd3, 5'd7, 0, 0, 0, 0);
        check("lu_release", vec_a, 8'h00);
        check("lu_cnt", cnt_a, 1);
        // load-use on rt
        next_cycle();
        drive(0, 1, 5'd9, 5'd1, 5'd9, 0, 0, 0, 0);
        check("lu_rt_vec", vec_b, 8'b1100_1000);
        // load into r0 is not a hazard
        next_cycle();
        drive(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check("lu_r0", vec_a, 8'h00);
        // branch alone, branch with load-use, jump alone
        next_cycle();
        drive(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
        check("branch_flush", vec_a, 8'b0010_0000);
        next_cycle();
        drive(0, 1, 5'd4, 5'd4, 5'd0, 1, 0, 0, 0);
        check("branch_vs_lu", vec_a, 8'b1100_1000);
        next_cycle();
        drive(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
        check("jump_flush", vec_a, 8'b0010_0000);

        // memory ready after 3 wait cycles; hazards ignored while frozen
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("mem_freeze", vec_a, 8'b1101_0110);
        next_cycle();
        drive(0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0);
        check("mem_ignore_hz", vec_a, 8'b1101_0110);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("mem_req_drop", vec_b, 8'b1101_0110);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        check("mem_ready_cyc", vec_a, 8'b1101_0110);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("mem_done_vec", vec_a, 8'h00);
        check("mem_done_cnt_a", cnt_a, 4);
        check("mem_done_cnt_b", cnt_b, 4);

        // timeout: err from cycle 5 on small build, saturation, reset recovery
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 16; c++) begin
            next_cycle();
            drive(0, 0, 0, 0, 0, 0, 0, (c <= 8), 0);
            check("timeout_err_b", err_b, (c >= 5));
        end
        check("sat_cnt_b", cnt_b, 7);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_vec_b", vec_b, 8'h00);
        check("rst_vec_a", vec_a, 8'h00);
        check("rst_cnt_b", cnt_b, 0);
        check("rst_cnt_a", cnt_a, 0);

        // timeout on default build: err from cycle MAX_WAIT+1
        for (int c = 1; c <= 70; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            check("timeout_err_a", err_a, (c >= 65));
            next_cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("timeout_cnt_a", cnt_a, 70);

        next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
